muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide unit alongside the single-cycle ALU in the processor datapath.
- Implements MULTU and DIVU into HI/LO registers.
- Accepts operands on a start/busy/done handshake and iterates one bit per cycle.
- Acts as the responder end of the operand-issue interface that the control unit drives.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  request; sampled only when busy=0
- op  input  1  0 = MULTU, 1 = DIVU
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; hi/lo hold the new result
- hi  output  WIDTH  MULTU: product[2W-1:W]; DIVU: remainder
- lo  output  WIDTH  MULTU: product[W-1:0]; DIVU: quotient

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0.
  - Any in-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge t0:
  - Latch a, b and op.
  - Clear the working registers; state=RUN, busy=1, done=0.
- RUN: one iteration per edge, at t1..tWIDTH; counter counts 0..WIDTH-1.
- At edge tWIDTH (final iteration):
  - Write hi/lo; state=DONE, busy=0, done=1.
  - Fixed latency: done is high in the cycle after edge t0+WIDTH, i.e. 33 cycles for WIDTH=32.
- DONE lasts one cycle, then goes to IDLE (done=0). If start=1 in DONE, a new operation is accepted immediately (back-to-back).
- hi/lo change only at completion and hold otherwise. They are not disturbed during RUN, so the previous result stays readable.
- start while busy=1: ignored. Latched operands and op are not resampled.
- MULTU, shift-add:
  - 2W+1-bit accumulator {carry, P_hi, P_lo}, with P_lo initialised to b.
  - Each iteration: if P_lo[0], P_hi += a_latched (with carry). Then shift the whole accumulator right by 1.
- DIVU, restoring:
  - Remainder register R (W+1 bits), quotient register Q initialised to a.
  - Each iteration: R = {R[W-1:0], Q[W-1]}, Q <<= 1.
  - If R >= b_latched: R -= b_latched, Q[0] = 1.
- Divide by zero: same algorithm and same latency, no special case. Result: lo = all ones, hi = a.
- All arithmetic is unsigned; no overflow flag. Outputs are registered with no combinational paths from inputs.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings MD_MULTU=1'b0, MD_DIVU=1'b1
  - state encoding MD_IDLE, MD_RUN, MD_DONE
- The counter width is derived as $clog2(WIDTH) in the package's usage, not hard-coded.
- Single module; no sub-module. The control FSM and datapath are small enough to share one always block pair.

Test Plan:
- MULTU a=7, b=6, start pulsed one cycle:
  - busy=1 for exactly 32 cycles, then done=1 for one cycle with hi=0, lo=42.
  - done=0 on the following cycle.
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
- DIVU a=100, b=7 -> lo=14, hi=2 after 33 cycles. A follow-up DIVU a=7, b=100 -> lo=0, hi=7.
- DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, same 33-cycle latency.
- Ignored start and reset mid-operation:
  - Start MULTU 3*4; at cycle 5 pulse start with a=9, b=9. Result is still hi=0, lo=12.
  - Then start again and drive reset=0 at cycle 10: busy=0, done=0, hi=lo=0 immediately (before the next clock edge).
  - No done pulse afterwards.
- Back-to-back: assert start during the done cycle of a DIVU 100/7 with MULTU 5*5.
  - First result lo=14, hi=2 is visible in the done cycle.
  - busy rises the next cycle; second done after 33 cycles with hi=0, lo=25.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//
// Shared definitions for the multi-cycle unsigned multiply/divide unit.
//
// Contents:
//   MD_MULTU / MD_DIVU : operation select encodings driven on the 'op' port
//   md_state_t         : control state encoding (IDLE, RUN, DONE)
//   md_cnt_width()     : width of the iteration counter for a given operand
//                        width, so the counter is never hard-coded
// ---------------------------------------------------------------------------
package muldiv_pkg;

    // Operation select as seen on the op input of the unit
    localparam logic MD_MULTU = 1'b0;
    localparam logic MD_DIVU  = 1'b1;

    // Control states of the iterative unit
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Counter must index iterations 0..width-1; guard the degenerate width=1
    // case so the counter is always at least one bit wide.
    function automatic int md_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle unsigned MULTU / DIVU unit writing the HI/LO register pair.
// One bit is processed per clock, so every operation takes exactly WIDTH
// iterations after the start edge regardless of operand values.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset (asserted when 0)
//   start  : operation request, only sampled while busy=0
//   op     : MD_MULTU (0) or MD_DIVU (1)
//   a      : multiplicand / dividend
//   b      : multiplier / divisor
//   busy   : operation in progress
//   done   : one-cycle pulse, hi/lo hold the new result
//   hi     : MULTU product upper half / DIVU remainder
//   lo     : MULTU product lower half / DIVU quotient
//
// MULTU uses a shift-add accumulator {carry, P_hi, P_lo} with P_lo seeded
// with b. DIVU uses restoring division with remainder R (WIDTH+1 bits) and
// quotient Q seeded with a. Both algorithms share the same two working
// registers: work_hi holds {carry, P_hi} or R, work_lo holds P_lo or Q.
// Divide by zero needs no special case: every trial subtraction succeeds,
// giving Q = all ones and R = a.
// ---------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = md_cnt_width(WIDTH);

    md_state_t        state;
    logic [CW-1:0]    counter;
    logic             op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   work_hi;
    logic [WIDTH-1:0] work_lo;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH:0]   next_hi;
    logic [WIDTH-1:0] next_lo;
    logic             last_iter;

    // One iteration of the selected algorithm, computed from the current
    // working registers. The sequential block simply loads these values on
    // every RUN edge, and on the final edge also copies them to hi/lo.
    //
    // MULTU: conditionally add a to {carry, P_hi}, then shift the whole
    // 2W+1 bit accumulator right by one. The carry is always zero at the
    // start of an iteration because the previous shift cleared it.
    //
    // DIVU: shift the next dividend bit from Q into R, then subtract b if
    // it fits and record the quotient bit in the freed LSB of Q.
    always_comb begin
        mul_sum   = work_hi + (work_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        div_shift = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        next_hi   = work_hi;
        next_lo   = work_lo;
        if (op_q == MD_MULTU) begin
            next_hi = {1'b0, mul_sum[WIDTH:1]};
            next_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else if (div_shift >= {1'b0, b_q}) begin
            next_hi = div_diff;
            next_lo = {work_lo[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = div_shift;
            next_lo = {work_lo[WIDTH-2:0], 1'b0};
        end
    end

    // The counter value WIDTH-1 marks the edge that performs the last
    // iteration and publishes the result.
    assign last_iter = (counter == CW'(WIDTH - 1));

    // Control FSM and datapath registers. hi/lo are only written on the
    // final iteration so the previous result stays readable while a new
    // operation runs. DONE behaves like IDLE for accepting start, which
    // allows back-to-back operations without an idle bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MD_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            counter <= '0;
            op_q    <= MD_MULTU;
            a_q     <= '0;
            b_q     <= '0;
            work_hi <= '0;
            work_lo <= '0;
        end else begin
            case (state)
                MD_IDLE, MD_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        work_hi <= '0;
                        work_lo <= (op == MD_DIVU) ? a : b;
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= MD_RUN;
                    end else begin
                        state <= MD_IDLE;
                    end
                end

                MD_RUN: begin
                    work_hi <= next_hi;
                    work_lo <= next_lo;
                    if (last_iter) begin
                        hi      <= next_hi[WIDTH-1:0];
                        lo      <= next_lo;
                        counter <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= MD_DONE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule
